// File: rtl/fp_norm_shift32.sv
// Mantissa normaliser: shifts by the LZ count, adjusts the exponent and
// clamps to subnormal when the exponent would underflow. Two-stage pipe.
module fp_norm_shift32 #(
  parameter int MANT_W = 32,
  parameter int LZ_W   = $clog2(MANT_W),
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [LZ_W-1:0]   in_lz,
  input  logic              in_nz,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uf,
  output logic              lz_err
);

  logic              s1_v;
  logic              s2_v;
  logic [MANT_W-1:0] s1_mant;
  logic [LZ_W-1:0]   s1_sh;
  logic [EXP_W-1:0]  s1_exp;
  logic              s1_zero;
  logic              s1_uf;

  logic s1_load;
  logic s2_load;
  logic accept;

  assign s2_load  = !s2_v || out_ready;
  assign s1_load  = !s1_v || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && in_ready;

  logic [EXP_W-1:0] lz_ext;
  logic             lz_lt;
  logic [LZ_W-1:0]  d_sh;
  logic [EXP_W-1:0] d_exp;
  logic             d_zero;
  logic             d_uf;

  assign lz_ext = EXP_W'(in_lz);
  assign lz_lt  = lz_ext < in_exp;

  always_comb begin
    d_sh   = '0;
    d_exp  = '0;
    d_zero = 1'b0;
    d_uf   = 1'b0;
    unique case (1'b1)
      !in_nz: begin
        d_zero = 1'b1;
      end
      in_nz && lz_lt: begin
        d_sh  = in_lz;
        d_exp = in_exp - lz_ext;
      end
      in_nz && !lz_lt: begin
        d_uf = 1'b1;
        // in_exp <= in_lz here, so in_exp-1 always fits the shift width
        d_sh = (in_exp == '0) ? '0 : LZ_W'(in_exp - EXP_W'(1));
      end
    endcase
  end

  logic [MANT_W-1:0] lz_top;
  logic              lz_bad;

  assign lz_top = in_mant >> (LZ_W'(MANT_W - 1) - in_lz);
  assign lz_bad = in_nz ? (lz_top != MANT_W'(1)) : (in_mant != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_mant <= '0;
      s1_sh   <= '0;
      s1_exp  <= '0;
      s1_zero <= 1'b0;
      s1_uf   <= 1'b0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_mant <= in_mant;
        s1_sh   <= d_sh;
        s1_exp  <= d_exp;
        s1_zero <= d_zero;
        s1_uf   <= d_uf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lz_err <= 1'b0;
    end else if (accept && lz_bad) begin
      lz_err <= 1'b1;
    end
  end

  logic [MANT_W-1:0] lvl [LZ_W+1];
  logic [MANT_W-1:0] sh_mant;

  assign lvl[0] = s1_mant;

  for (genvar i = 0; i < LZ_W; i++) begin : g_bs
    assign lvl[i+1] = s1_sh[i] ? (lvl[i] << (1 << i)) : lvl[i];
  end

  assign sh_mant = s1_zero ? '0 : lvl[LZ_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      out_mant <= '0;
      out_exp  <= '0;
      out_zero <= 1'b0;
      out_uf   <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_mant <= sh_mant;
        out_exp  <= s1_exp;
        out_zero <= s1_zero;
        out_uf   <= s1_uf;
      end
    end
  end

  assign out_valid = s2_v;

endmodule
